// File: rtl/port_alloc_pipe.sv
`default_nettype none
// ============================================================================
// Module      : port_alloc_pipe
// Description : Single-stage output-port allocator for a bufferless router.
//               Each valid channel gets exactly one port. A channel first tries
//               for a productive port, then falls back to a deflection to a
//               free network port, and finally to the shared bypass port.
//               Deflections are counted in a saturating statistics counter.
// Revision    : 1.0 - initial release
// ============================================================================
module port_alloc_pipe #(
  parameter int NUM_CHANNEL = 5,
  parameter int PRIO_MODE   = 1,
  parameter int CNT_WIDTH   = 16,
  localparam int NUM_PORT   = NUM_CHANNEL + 1,
  localparam int PTR_W      = $clog2(NUM_CHANNEL)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            in_valid,
  input  logic [NUM_CHANNEL-1:0]          valid_vector,
  input  logic [NUM_CHANNEL*NUM_CHANNEL-1:0] pv_in,
  input  logic                            stall,
  input  logic                            clr_stats,
  output logic                            out_valid,
  output logic [NUM_CHANNEL*NUM_PORT-1:0] pv_out,
  output logic [NUM_CHANNEL-1:0]          deflect_vec,
  output logic [PTR_W-1:0]                prio_ptr,
  output logic [CNT_WIDTH-1:0]            defl_total
);

  // Bit positions inside a granted port vector
  localparam int LOCAL_BIT  = NUM_CHANNEL - 1;
  localparam int BYPASS_BIT = NUM_CHANNEL;

  logic                            accept;
  logic [NUM_CHANNEL-1:0]          free_ports;   // network + local ports still unclaimed
  logic [NUM_CHANNEL*NUM_PORT-1:0] alloc_pv;
  logic [NUM_CHANNEL-1:0]          alloc_defl;
  logic [NUM_CHANNEL-1:0]          avail;
  logic [NUM_PORT-1:0]             grant;
  logic                            found;
  int                              cur_ch;
  logic [CNT_WIDTH:0]              defl_cnt;
  logic [CNT_WIDTH:0]              defl_sum;
  logic [CNT_WIDTH-1:0]            defl_next;

  assign accept = in_valid & ~stall;

  // Sequential allocation walk in priority order, starting at prio_ptr.
  // The channel loop uses constant indices so that every select is static.
  always_comb begin
    free_ports = '1;
    alloc_pv   = '0;
    alloc_defl = '0;
    avail      = '0;
    grant      = '0;
    found      = 1'b0;
    cur_ch     = 0;
    for (int k = 0; k < NUM_CHANNEL; k++) begin
      cur_ch = int'(prio_ptr) + k;
      if (cur_ch >= NUM_CHANNEL) cur_ch = cur_ch - NUM_CHANNEL;
      for (int c = 0; c < NUM_CHANNEL; c++) begin
        if (c == cur_ch && valid_vector[c]) begin
          grant = '0;
          found = 1'b0;
          avail = pv_in[c*NUM_CHANNEL +: NUM_CHANNEL] & free_ports;
          // Ascending scan, last hit wins: highest free requested port
          for (int b = 0; b < NUM_CHANNEL; b++) begin
            if (avail[b]) begin
              grant    = '0;
              grant[b] = 1'b1;
              found    = 1'b1;
            end
          end
          if (!found) begin
            // Descending scan over network ports only, last hit wins: lowest
            // free one. The local port is never a deflection target.
            for (int b = LOCAL_BIT - 1; b >= 0; b--) begin
              if (free_ports[b]) begin
                grant    = '0;
                grant[b] = 1'b1;
                found    = 1'b1;
              end
            end
            if (!found) grant[BYPASS_BIT] = 1'b1;
            alloc_defl[c] = 1'b1;
          end
          // Bypass is not part of free_ports, so it can be shared freely
          free_ports = free_ports & ~grant[NUM_CHANNEL-1:0];
          alloc_pv[c*NUM_PORT +: NUM_PORT] = grant;
        end
      end
    end
  end

  // Count the deflections of this group and form the saturated total
  always_comb begin
    defl_cnt = '0;
    for (int b = 0; b < NUM_CHANNEL; b++) begin
      defl_cnt = defl_cnt + {{CNT_WIDTH{1'b0}}, alloc_defl[b]};
    end
    defl_sum  = {1'b0, defl_total} + defl_cnt;
    defl_next = defl_sum[CNT_WIDTH] ? '1 : defl_sum[CNT_WIDTH-1:0];
  end

  // Output register: loads the allocation on an accepted group, zeros on an
  // idle cycle, holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      pv_out      <= '0;
      deflect_vec <= '0;
    end else if (!stall) begin
      out_valid   <= in_valid;
      pv_out      <= in_valid ? alloc_pv   : '0;
      deflect_vec <= in_valid ? alloc_defl : '0;
    end
  end

  // Deflection statistics: clear wins over increment and ignores stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      defl_total <= '0;
    end else if (clr_stats) begin
      defl_total <= '0;
    end else if (accept) begin
      defl_total <= defl_next;
    end
  end

  generate
    if (PRIO_MODE == 1) begin : g_rotate
      // Rotate the priority pointer after every non-empty accepted group
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prio_ptr <= '0;
        end else if (accept && (|valid_vector)) begin
          prio_ptr <= (prio_ptr == PTR_W'(NUM_CHANNEL - 1)) ? '0 : prio_ptr + PTR_W'(1);
        end
      end
    end else begin : g_fixed
      assign prio_ptr = '0;
    end
  endgenerate

endmodule
`default_nettype wire
